// File: rtl/corner_editor.sv
// corner_editor: manual quadrilateral corner adjustment stage.
//
// Loads four auto-detected corners on a one-cycle set_corners_i pulse, with
// each coordinate clamped to X_MAX/Y_MAX. While edit_enable_i is high, the
// user cycles the selected corner with button_select_i and moves it with the
// direction buttons. Every result is clamped to [0, MAX] and never wraps.
//
// Build option: define CORNER_EDITOR_AUTOREPEAT_EN to build hold-to-repeat.
// The first step comes immediately, the next after REPEAT_DELAY cycles, then
// one every REPEAT_PERIOD cycles. Without the macro, each change of the
// direction vector gives exactly one step and no counter is built.
//
// Ports:
//   clk_i, reset_ni        clock, asynchronous active-low reset
//   set_corners_i          one-cycle load pulse; takes priority over edits
//   edit_enable_i          high while manual editing is permitted
//   auto_corners_i         4 x {y, x}; corner i x at [i*(XW+YW) +: XW]
//   button_*_i             debounced button levels
//   corners_o              edited corners, same packing as auto_corners_i
//   selected_o             index of the corner being edited
//   corners_valid_o        high once corners have been loaded
module corner_editor #(
  parameter int unsigned X_WIDTH       = 10,
  parameter int unsigned Y_WIDTH       = 10,
  parameter int unsigned X_MAX         = 639,
  parameter int unsigned Y_MAX         = 479,
  parameter int unsigned STEP          = 1,
  parameter int unsigned REPEAT_DELAY  = 32500000,
  parameter int unsigned REPEAT_PERIOD = 3250000
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               set_corners_i,
  input  logic                               edit_enable_i,
  input  logic [4*(X_WIDTH+Y_WIDTH)-1:0]     auto_corners_i,
  input  logic                               button_select_i,
  input  logic                               button_up_i,
  input  logic                               button_down_i,
  input  logic                               button_left_i,
  input  logic                               button_right_i,
  output logic [4*(X_WIDTH+Y_WIDTH)-1:0]     corners_o,
  output logic [1:0]                         selected_o,
  output logic                               corners_valid_o
);

  localparam int unsigned CW = X_WIDTH + Y_WIDTH;

  localparam logic [X_WIDTH-1:0]        XMax  = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0]        YMax  = Y_WIDTH'(Y_MAX);
  localparam logic signed [X_WIDTH:0]   XMaxS = (X_WIDTH+1)'(X_MAX);
  localparam logic signed [Y_WIDTH:0]   YMaxS = (Y_WIDTH+1)'(Y_MAX);
  localparam logic signed [X_WIDTH:0]   XStep = (X_WIDTH+1)'(STEP);
  localparam logic signed [Y_WIDTH:0]   YStep = (Y_WIDTH+1)'(STEP);

  // Corner state
  logic [X_WIDTH-1:0] cx_q [4];
  logic [X_WIDTH-1:0] cx_d [4];
  logic [Y_WIDTH-1:0] cy_q [4];
  logic [Y_WIDTH-1:0] cy_d [4];
  logic [1:0]         selected_q, selected_d;
  logic               valid_q, valid_d;

  // Previous button levels, sampled every cycle regardless of enable
  logic               select_prev_q;
  logic [3:0]         dir_q;
  logic [3:0]         dir;

  logic               sel_edge;
  logic               dir_new;
  logic               step_fire;

  // Unpacked auto-detected corners
  logic [X_WIDTH-1:0] auto_x [4];
  logic [Y_WIDTH-1:0] auto_y [4];

  // Stepped coordinates of the selected corner
  logic signed [X_WIDTH:0] x_cur, x_sum;
  logic signed [Y_WIDTH:0] y_cur, y_sum;
  logic [X_WIDTH-1:0]      x_new;
  logic [Y_WIDTH-1:0]      y_new;

  // D = {up, down, left, right}
  assign dir      = {button_up_i, button_down_i, button_left_i, button_right_i};
  assign dir_new  = (dir != 4'b0000) && (dir != dir_q);
  assign sel_edge = edit_enable_i && button_select_i && !select_prev_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      auto_x[i] = auto_corners_i[i*CW +: X_WIDTH];
      auto_y[i] = auto_corners_i[i*CW+X_WIDTH +: Y_WIDTH];
    end
  end

`ifdef CORNER_EDITOR_AUTOREPEAT_EN
  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (set_corners_i || !edit_enable_i || (dir == 4'b0000)) begin
      state_d = StIdle;
    end else if (dir_new) begin
      // A fresh press or a change mid-hold restarts the delay
      state_d = StDelay;
      cnt_d   = CntW'(REPEAT_DELAY - 1);
    end else begin
      unique case (state_q)
        StDelay, StRepeat: begin
          if (cnt_q == '0) begin
            state_d = StRepeat;
            cnt_d   = CntW'(REPEAT_PERIOD - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        // Held since before enable rose: wait for D to change
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic: step strobe
  always_comb begin
    step_fire = 1'b0;
    if (edit_enable_i && (dir != 4'b0000)) begin
      if (dir_new) begin
        step_fire = 1'b1;
      end else if ((state_q != StIdle) && (cnt_q == '0)) begin
        step_fire = 1'b1;
      end
    end
  end
`else
  // One step per change of the direction vector; repeat timing is not built
  assign step_fire = edit_enable_i && dir_new;

  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // Step arithmetic on the selected corner, one bit wider and signed
  always_comb begin
    x_cur = $signed({1'b0, cx_q[selected_q]});
    y_cur = $signed({1'b0, cy_q[selected_q]});
    x_sum = x_cur;
    y_sum = y_cur;
    // Opposing buttons on one axis cancel; the other axis is unaffected
    if (button_left_i && !button_right_i) x_sum = x_cur - XStep;
    if (button_right_i && !button_left_i) x_sum = x_cur + XStep;
    if (button_up_i && !button_down_i)    y_sum = y_cur - YStep;
    if (button_down_i && !button_up_i)    y_sum = y_cur + YStep;

    if (x_sum[X_WIDTH])      x_new = '0;
    else if (x_sum > XMaxS)  x_new = XMax;
    else                     x_new = x_sum[X_WIDTH-1:0];

    if (y_sum[Y_WIDTH])      y_new = '0;
    else if (y_sum > YMaxS)  y_new = YMax;
    else                     y_new = y_sum[Y_WIDTH-1:0];
  end

  // Corner / selection next state; load wins over any edit
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cx_d[i] = cx_q[i];
      cy_d[i] = cy_q[i];
    end
    selected_d = selected_q;
    valid_d    = valid_q;
    if (set_corners_i) begin
      for (int i = 0; i < 4; i++) begin
        cx_d[i] = (auto_x[i] > XMax) ? XMax : auto_x[i];
        cy_d[i] = (auto_y[i] > YMax) ? YMax : auto_y[i];
      end
      selected_d = 2'd0;
      valid_d    = 1'b1;
    end else begin
      // The step uses the current selection; a new selection applies next cycle
      if (step_fire) begin
        cx_d[selected_q] = x_new;
        cy_d[selected_q] = y_new;
      end
      if (sel_edge) begin
        selected_d = selected_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < 4; i++) begin
        cx_q[i] <= '0;
        cy_q[i] <= '0;
      end
      selected_q    <= 2'd0;
      valid_q       <= 1'b0;
      select_prev_q <= 1'b0;
      dir_q         <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cx_q[i] <= cx_d[i];
        cy_q[i] <= cy_d[i];
      end
      selected_q    <= selected_d;
      valid_q       <= valid_d;
      select_prev_q <= button_select_i;
      dir_q         <= dir;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      corners_o[i*CW +: X_WIDTH]         = cx_q[i];
      corners_o[i*CW+X_WIDTH +: Y_WIDTH] = cy_q[i];
    end
  end

  assign selected_o      = selected_q;
  assign corners_valid_o = valid_q;

endmodule

// File: tb/tb_corner_editor.sv
module tb_corner_editor;

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = XW + YW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              set_corners;
  logic              edit_enable;
  logic [4*CW-1:0]   auto_corners;
  logic              b_sel, b_up, b_down, b_left, b_right;
  logic [4*CW-1:0]   corners;
  logic [1:0]        selected;
  logic              corners_valid;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  corner_editor #(
    .X_WIDTH       (XW),
    .Y_WIDTH       (YW),
    .X_MAX         (639),
    .Y_MAX         (479),
    .STEP          (1),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) u_dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .set_corners_i   (set_corners),
    .edit_enable_i   (edit_enable),
    .auto_corners_i  (auto_corners),
    .button_select_i (b_sel),
    .button_up_i     (b_up),
    .button_down_i   (b_down),
    .button_left_i   (b_left),
    .button_right_i  (b_right),
    .corners_o       (corners),
    .selected_o      (selected),
    .corners_valid_o (corners_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int unsigned cx(input int i);
    return int'(corners[i*CW +: XW]);
  endfunction

  function automatic int unsigned cy(input int i);
    return int'(corners[i*CW+XW +: YW]);
  endfunction

  task automatic set_auto(input int i, input int unsigned x, input int unsigned y);
    auto_corners[i*CW +: XW]    = XW'(x);
    auto_corners[i*CW+XW +: YW] = YW'(y);
  endtask

  task automatic sel_edge();
    b_sel = 1'b1;
    tick();
    b_sel = 1'b0;
    tick();
  endtask

  initial begin
    reset_n      = 1'b1;
    set_corners  = 1'b0;
    edit_enable  = 1'b0;
    auto_corners = '0;
    {b_sel, b_up, b_down, b_left, b_right} = 5'b0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_corners", (corners == '0) ? 1 : 0, 1);
    check("rst_selected", selected, 0);
    check("rst_valid", corners_valid, 0);
    tick(2);
    reset_n = 1'b1;
    tick();

    // Load with clamping
    set_auto(0, 700, 500);
    set_auto(1, 10, 20);
    set_auto(2, 100, 200);
    set_auto(3, 639, 479);
    set_corners = 1'b1;
    tick();
    set_corners = 1'b0;
    check("load_c0x", cx(0), 639);
    check("load_c0y", cy(0), 479);
    check("load_c1x", cx(1), 10);
    check("load_c1y", cy(1), 20);
    check("load_c2y", cy(2), 200);
    check("load_valid", corners_valid, 1);
    check("load_sel", selected, 0);

    // Clamp at max, single steps, opposing buttons
    edit_enable = 1'b1;
    b_right = 1'b1; tick(); b_right = 1'b0; tick();
    check("clamp_right_x", cx(0), 639);
    b_left = 1'b1; tick(); b_left = 1'b0; tick();
    check("tap_left_x", cx(0), 638);
    b_up = 1'b1; b_down = 1'b1; b_left = 1'b1; tick();
    b_up = 1'b0; b_down = 1'b0; b_left = 1'b0; tick();
    check("updown_y", cy(0), 479);
    check("updown_left_x", cx(0), 637);

    // Select corner 1, then hold down for 20 cycles
    sel_edge();
    check("sel_1", selected, 1);
    b_down = 1'b1;
    tick(9);
`ifdef CORNER_EDITOR_AUTOREPEAT_EN
    check("repeat_y_mid", cy(1), 22);
`else
    check("repeat_y_mid", cy(1), 21);
`endif
    tick(11);
    b_down = 1'b0;
    tick();
`ifdef CORNER_EDITOR_AUTOREPEAT_EN
    check("repeat_y_end", cy(1), 24);
`else
    check("repeat_y_end", cy(1), 21);
`endif
    check("repeat_c0_untouched", cy(0), 479);

    // Select wrap
    sel_edge();
    check("sel_2", selected, 2);
    sel_edge();
    check("sel_3", selected, 3);
    sel_edge();
    check("sel_0", selected, 0);

    // Disabled: no select, no step; held buttons stay silent after enable
    edit_enable = 1'b0;
    sel_edge();
    check("dis_sel", selected, 0);
    b_left = 1'b1;
    tick(2);
    check("dis_step_x", cx(0), 637);
    edit_enable = 1'b1;
    tick();
    check("held_at_enable_x", cx(0), 637);
    b_left = 1'b0;
    tick();
    sel_edge();
    check("sel_again_1", selected, 1);

    // Load beats a same-cycle left press; held left stays silent after
    set_auto(0, 5, 0);
    set_corners = 1'b1;
    b_left = 1'b1;
    tick();
    set_corners = 1'b0;
    check("prio_x", cx(0), 5);
    check("prio_sel", selected, 0);
    tick();
    check("prio_held_x", cx(0), 5);
    b_left = 1'b0;
    tick();
    b_left = 1'b1; b_up = 1'b1; tick();
    b_left = 1'b0; b_up = 1'b0; tick();
    check("repress_x", cx(0), 4);
    check("clamp_zero_y", cy(0), 0);

    // Asynchronous reset mid-hold, between clock edges
    b_right = 1'b1;
    tick(2);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_corners", (corners == '0) ? 1 : 0, 1);
    check("async_rst_sel", selected, 0);
    check("async_rst_valid", corners_valid, 0);
    b_right = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
